// File: rtl/rv_mem_arb_pkg.sv
// Shared encodings and helpers for the memory-port arbiter between the
// multicycle core and the debug/program-loader port.
package rv_mem_arb_pkg;

  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_BUSY = 2'd1;
  localparam logic [1:0] ARB_DONE = 2'd2;

  localparam logic OWN_CORE = 1'b0;
  localparam logic OWN_DBG  = 1'b1;

  localparam int WDOG_W = 8;

  // One latched access; these fields alone drive the memory side while BUSY.
  typedef struct packed {
    logic        owner;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } acc_t;

  function automatic logic [WDOG_W-1:0] wdog_inc(input logic [WDOG_W-1:0] cnt);
    return (cnt == '1) ? cnt : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/rv_mem_arb.sv
// Arbitrates the single memory port between core and debug requesters,
// sequencing one registered access at a time with an ack-or-timeout watchdog.
module rv_mem_arb
  import rv_mem_arb_pkg::*;
#(
  parameter bit          FAIR    = 1'b1,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  output logic [31:0] c_rdata,
  output logic        c_done,
  output logic        c_err,
  output logic        stall,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        d_err,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ack
);

  logic [1:0]        state_q, state_d;
  acc_t              acc_q, acc_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              err_q, err_d;
  logic              last_q, last_d;
  logic [31:0]       c_rdata_q, c_rdata_d;
  logic [31:0]       d_rdata_q, d_rdata_d;
  logic              grant_owner;
  logic              timeout_hit;

  always_comb begin
    grant_owner = OWN_CORE;
    if (c_req && d_req) begin
      grant_owner = FAIR ? ~last_q : OWN_CORE;
    end else if (d_req) begin
      grant_owner = OWN_DBG;
    end
  end

  // wdog_q holds the BUSY cycles already spent, so +1 counts the current one.
  assign timeout_hit = (TIMEOUT != 0) && ((32'(wdog_q) + 32'd1) >= TIMEOUT);

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    wdog_d    = wdog_q;
    err_d     = err_q;
    last_d    = last_q;
    c_rdata_d = c_rdata_q;
    d_rdata_d = d_rdata_q;
    case (state_q)
      ARB_IDLE: begin
        if (c_req || d_req) begin
          acc_d.owner = grant_owner;
          acc_d.we    = (grant_owner == OWN_DBG) ? d_we    : c_we;
          acc_d.addr  = (grant_owner == OWN_DBG) ? d_addr  : c_addr;
          acc_d.wdata = (grant_owner == OWN_DBG) ? d_wdata : c_wdata;
          wdog_d      = '0;
          err_d       = 1'b0;
          state_d     = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        wdog_d = wdog_inc(wdog_q);
        if (m_ack) begin
          if (!acc_q.we) begin
            if (acc_q.owner == OWN_DBG) d_rdata_d = m_rdata;
            else                        c_rdata_d = m_rdata;
          end
          last_d  = acc_q.owner;
          state_d = ARB_DONE;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          last_d  = acc_q.owner;
          state_d = ARB_DONE;
        end
      end
      ARB_DONE: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ARB_IDLE;
      acc_q     <= '0;
      wdog_q    <= '0;
      err_q     <= 1'b0;
      last_q    <= OWN_DBG;
      c_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      wdog_q    <= wdog_d;
      err_q     <= err_d;
      last_q    <= last_d;
      c_rdata_q <= c_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign m_req   = (state_q == ARB_BUSY);
  assign m_we    = acc_q.we;
  assign m_addr  = acc_q.addr;
  assign m_wdata = acc_q.wdata;

  assign c_done  = (state_q == ARB_DONE) && (acc_q.owner == OWN_CORE);
  assign d_done  = (state_q == ARB_DONE) && (acc_q.owner == OWN_DBG);
  assign c_err   = c_done && err_q;
  assign d_err   = d_done && err_q;
  assign c_rdata = c_rdata_q;
  assign d_rdata = d_rdata_q;

  // The one combinational input-to-output path: freezes the core FSM.
  assign stall   = c_req && !c_done;

endmodule

// File: tb/tb_rv_mem_arb.sv
// Self-checking bench: a fair/watchdog instance and a core-priority/no-watchdog
// instance run against a cycle-timestamp reference model plus literal checks.
module tb_rv_mem_arb;

  localparam int NI  = 2;
  localparam int TO0 = 4;
  localparam int TO1 = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        c_req[NI], c_we[NI], d_req[NI], d_we[NI], m_ack[NI];
  logic [31:0] c_addr[NI], c_wdata[NI], d_addr[NI], d_wdata[NI], m_rdata[NI];
  logic [31:0] c_rdata[NI], d_rdata[NI], m_addr[NI], m_wdata[NI];
  logic        c_done[NI], c_err[NI], d_done[NI], d_err[NI], stall[NI], m_req[NI], m_we[NI];

  rv_mem_arb #(.FAIR(1'b1), .TIMEOUT(TO0)) u_fair (
    .clk(clk), .rst(rst),
    .c_req(c_req[0]), .c_we(c_we[0]), .c_addr(c_addr[0]), .c_wdata(c_wdata[0]),
    .c_rdata(c_rdata[0]), .c_done(c_done[0]), .c_err(c_err[0]), .stall(stall[0]),
    .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
    .d_rdata(d_rdata[0]), .d_done(d_done[0]), .d_err(d_err[0]),
    .m_req(m_req[0]), .m_we(m_we[0]), .m_addr(m_addr[0]), .m_wdata(m_wdata[0]),
    .m_rdata(m_rdata[0]), .m_ack(m_ack[0])
  );

  rv_mem_arb #(.FAIR(1'b0), .TIMEOUT(TO1)) u_prio (
    .clk(clk), .rst(rst),
    .c_req(c_req[1]), .c_we(c_we[1]), .c_addr(c_addr[1]), .c_wdata(c_wdata[1]),
    .c_rdata(c_rdata[1]), .c_done(c_done[1]), .c_err(c_err[1]), .stall(stall[1]),
    .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
    .d_rdata(d_rdata[1]), .d_done(d_done[1]), .d_err(d_err[1]),
    .m_req(m_req[1]), .m_we(m_we[1]), .m_addr(m_addr[1]), .m_wdata(m_wdata[1]),
    .m_rdata(m_rdata[1]), .m_ack(m_ack[1])
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  function automatic bit fair_of(input int k);
    return k == 0;
  endfunction

  function automatic int to_of(input int k);
    return (k == 0) ? TO0 : TO1;
  endfunction

  function automatic void chk(input string nm, input int k, input logic [31:0] act,
                              input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] cycle %0d: got %0h, want %0h", nm, k, cyc, act, exp);
    end
  endfunction

  // Reference model: an access is a granted record plus the number of
  // memory cycles it has consumed; done is shown for one cycle after it ends.
  bit          mo_busy[NI], mo_done[NI], mo_own[NI], mo_we[NI], mo_err[NI];
  bit          mo_last[NI], mo_inrst[NI];
  int          mo_len[NI];
  logic [31:0] mo_addr[NI], mo_wd[NI], mo_rdc[NI], mo_rdd[NI];

  task automatic model_step(input int k);
    if (!rst) begin
      mo_busy[k] = 0; mo_done[k] = 0; mo_err[k] = 0; mo_last[k] = 1;
      mo_rdc[k] = '0; mo_rdd[k] = '0; mo_we[k] = 0; mo_addr[k] = '0; mo_wd[k] = '0;
      mo_inrst[k] = 1;
      return;
    end
    mo_inrst[k] = 0;
    if (mo_done[k]) begin
      mo_done[k] = 0;
    end else if (!mo_busy[k]) begin
      if (c_req[k] || d_req[k]) begin
        if (c_req[k] && d_req[k]) mo_own[k] = fair_of(k) ? !mo_last[k] : 1'b0;
        else                      mo_own[k] = d_req[k];
        mo_we[k]   = mo_own[k] ? d_we[k]    : c_we[k];
        mo_addr[k] = mo_own[k] ? d_addr[k]  : c_addr[k];
        mo_wd[k]   = mo_own[k] ? d_wdata[k] : c_wdata[k];
        mo_busy[k] = 1; mo_len[k] = 0; mo_err[k] = 0;
      end
    end else begin
      mo_len[k]++;
      if (m_ack[k]) begin
        if (!mo_we[k]) begin
          if (mo_own[k]) mo_rdd[k] = m_rdata[k];
          else           mo_rdc[k] = m_rdata[k];
        end
        mo_busy[k] = 0; mo_done[k] = 1; mo_last[k] = mo_own[k];
      end else if (to_of(k) != 0 && mo_len[k] >= to_of(k)) begin
        mo_busy[k] = 0; mo_done[k] = 1; mo_err[k] = 1; mo_last[k] = mo_own[k];
      end
    end
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) model_step(k);
    #1;
    cyc++;
    for (int k = 0; k < NI; k++) begin
      chk("m_req",   k, 32'(m_req[k]),  32'(mo_busy[k]));
      chk("c_done",  k, 32'(c_done[k]), 32'(mo_done[k] && !mo_own[k]));
      chk("d_done",  k, 32'(d_done[k]), 32'(mo_done[k] &&  mo_own[k]));
      chk("c_err",   k, 32'(c_err[k]),  32'(mo_done[k] && !mo_own[k] && mo_err[k]));
      chk("d_err",   k, 32'(d_err[k]),  32'(mo_done[k] &&  mo_own[k] && mo_err[k]));
      chk("c_rdata", k, c_rdata[k], mo_rdc[k]);
      chk("d_rdata", k, d_rdata[k], mo_rdd[k]);
      chk("stall",   k, 32'(stall[k]),  32'(c_req[k] && !(mo_done[k] && !mo_own[k])));
      if (mo_busy[k] || mo_inrst[k]) begin
        chk("m_we",    k, 32'(m_we[k]), 32'(mo_we[k]));
        chk("m_addr",  k, m_addr[k],  mo_addr[k]);
        chk("m_wdata", k, m_wdata[k], mo_wd[k]);
      end
    end
  end

  // Memory responder: -1 random, -2 never acks, -3 acks constantly,
  // n >= 0 acks once m_req has been up for n+1 cycles.
  int          ack_lat[NI];
  int          rcnt[NI];
  bit          rd_fix_en[NI];
  logic [31:0] rd_fix[NI];

  always @(posedge clk) begin
    #1;
    for (int k = 0; k < NI; k++) begin
      if (m_req[k] === 1'b1) rcnt[k]++;
      else                   rcnt[k] = 0;
      m_rdata[k] = rd_fix_en[k] ? rd_fix[k] : $urandom;
      case (ack_lat[k])
        -1: m_ack[k] = (m_req[k] === 1'b1) ? ($urandom_range(0, 1) == 1)
                                           : ($urandom_range(0, 4) == 0);
        -2: m_ack[k] = 1'b0;
        -3: m_ack[k] = 1'b1;
        default: m_ack[k] = (m_req[k] === 1'b1) && (rcnt[k] >= ack_lat[k] + 1);
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic serve(input int k, input bit dbg, input bit keep, input int lim,
                       output int n, output int nreq, output bit err,
                       output logic [31:0] a0);
    n = -1; nreq = 0; err = 0; a0 = '0;
    for (int i = 1; i <= lim; i++) begin
      tick();
      if (m_req[k]) begin
        if (nreq == 0) a0 = m_addr[k];
        nreq++;
      end
      if (dbg ? d_done[k] : c_done[k]) begin
        n   = i;
        err = dbg ? d_err[k] : c_err[k];
        if (!keep) begin
          if (dbg) d_req[k] = 1'b0;
          else     c_req[k] = 1'b0;
        end
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    for (int k = 0; k < NI; k++) begin
      c_req[k] = 1'b0;
      d_req[k] = 1'b0;
    end
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  function automatic logic [31:0] exp_order(input int k, input int i);
    if (k == 0) begin
      case (i)
        0: return 32'h1000;
        1: return 32'h2000;
        2: return 32'h1001;
        default: return 32'h2001;
      endcase
    end
    case (i)
      0: return 32'h1000;
      1: return 32'h1001;
      2: return 32'h2000;
      default: return 32'h2001;
    endcase
  endfunction

  task automatic rand_fields(input int k, input bit dbg);
    if (dbg) begin
      d_we[k] = 1'($urandom_range(0, 1)); d_addr[k] = $urandom; d_wdata[k] = $urandom;
    end else begin
      c_we[k] = 1'($urandom_range(0, 1)); c_addr[k] = $urandom; c_wdata[k] = $urandom;
    end
  endtask

  initial begin
    int          n, nreq, cnt, dn, cn, no;
    bit          err, prev;
    logic [31:0] a0;
    logic [31:0] ord[4];

    rst = 1'b0;
    for (int k = 0; k < NI; k++) begin
      c_req[k] = 0; c_we[k] = 0; c_addr[k] = '0; c_wdata[k] = '0;
      d_req[k] = 0; d_we[k] = 0; d_addr[k] = '0; d_wdata[k] = '0;
      ack_lat[k] = -1; rd_fix_en[k] = 0; rd_fix[k] = '0;
    end
    repeat (3) tick();
    chk("rst_m_req",   0, 32'(m_req[0]), 32'd0);
    chk("rst_c_rdata", 0, c_rdata[0], 32'd0);
    chk("rst_m_addr",  1, m_addr[1],  32'd0);
    rst = 1'b1;
    tick();

    // Core read with ack in the fourth memory cycle.
    ack_lat[0] = 3; rd_fix_en[0] = 1; rd_fix[0] = 32'hDEADBEEF;
    c_we[0] = 0; c_addr[0] = 32'h100; c_req[0] = 1;
    serve(0, 0, 0, 20, n, nreq, err, a0);
    chk("t1_done_lat", 0, 32'(n), 32'd5);
    chk("t1_mreq_cyc", 0, 32'(nreq), 32'd4);
    chk("t1_addr",     0, a0, 32'h100);
    tick();
    chk("t1_rdata",    0, c_rdata[0], 32'hDEADBEEF);

    // Zero-wait write, then req held past done as a second access.
    ack_lat[0] = 0;
    c_we[0] = 1; c_addr[0] = 32'h200; c_wdata[0] = 32'h11112222; c_req[0] = 1;
    serve(0, 0, 1, 20, n, nreq, err, a0);
    chk("t2_done_lat", 0, 32'(n), 32'd2);
    chk("t2_mreq_cyc", 0, 32'(nreq), 32'd1);
    c_addr[0] = 32'h204;
    serve(0, 0, 0, 20, n, nreq, err, a0);
    chk("t2_b2b_lat",  0, 32'(n), 32'd3);
    chk("t2_b2b_addr", 0, a0, 32'h204);

    // Simultaneous writers, two accesses each.
    do_reset();
    for (int k = 0; k < NI; k++) begin
      ack_lat[k] = 1;
      c_we[k] = 1; d_we[k] = 1; c_addr[k] = 32'h1000; d_addr[k] = 32'h2000;
      c_req[k] = 1; d_req[k] = 1;
      cn = 0; dn = 0; no = 0; prev = 0;
      for (int i = 0; i < 4; i++) ord[i] = '0;
      for (int i = 0; i < 100 && (c_req[k] || d_req[k]); i++) begin
        tick();
        if (m_req[k] && !prev && no < 4) begin
          ord[no] = m_addr[k];
          no++;
        end
        prev = m_req[k];
        if (c_done[k]) begin
          cn++;
          if (cn < 2) c_addr[k] = 32'h1001;
          else        c_req[k] = 0;
        end
        if (d_done[k]) begin
          dn++;
          if (dn < 2) d_addr[k] = 32'h2001;
          else        d_req[k] = 0;
        end
      end
      for (int i = 0; i < 4; i++) chk("t3_order", k, ord[i], exp_order(k, i));
      tick();
    end

    // Watchdog abort on the fair instance, then a normal read.
    ack_lat[0] = -2; rd_fix[0] = 32'h5A5A0001;
    d_we[0] = 0; d_addr[0] = 32'h300; d_req[0] = 1;
    serve(0, 1, 0, 30, n, nreq, err, a0);
    chk("t4_to_lat",  0, 32'(n), 32'd5);
    chk("t4_to_mreq", 0, 32'(nreq), 32'd4);
    chk("t4_to_err",  0, 32'(err), 32'd1);
    tick();
    chk("t4_to_rdata", 0, d_rdata[0], 32'd0);
    ack_lat[0] = 1; d_addr[0] = 32'h304; d_req[0] = 1;
    serve(0, 1, 0, 30, n, nreq, err, a0);
    chk("t4_rec_lat", 0, 32'(n), 32'd3);
    chk("t4_rec_err", 0, 32'(err), 32'd0);
    tick();
    chk("t4_rec_rdata", 0, d_rdata[0], 32'h5A5A0001);

    // No watchdog: memory silence keeps m_req up indefinitely.
    ack_lat[1] = -2; c_we[1] = 0; c_addr[1] = 32'h400; c_req[1] = 1;
    cnt = 0; dn = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (m_req[1]) cnt++;
      if (c_done[1] || d_done[1]) dn++;
    end
    chk("t4_nowd_mreq", 1, 32'(cnt), 32'd40);
    chk("t4_nowd_done", 1, 32'(dn), 32'd0);
    rd_fix_en[1] = 1; rd_fix[1] = 32'h0BADF00D; ack_lat[1] = 0;
    serve(1, 0, 0, 10, n, nreq, err, a0);
    chk("t4_nowd_lat", 1, 32'(n), 32'd2);
    tick();
    chk("t4_nowd_rdata", 1, c_rdata[1], 32'h0BADF00D);

    // Reset in the middle of an access, then stray acks.
    for (int k = 0; k < NI; k++) begin
      ack_lat[k] = -2; c_we[k] = 0; c_addr[k] = 32'h500; c_req[k] = 1;
    end
    repeat (3) tick();
    rst = 1'b0;
    tick();
    for (int k = 0; k < NI; k++) begin
      chk("t5_m_req",   k, 32'(m_req[k]), 32'd0);
      chk("t5_c_done",  k, 32'(c_done[k]), 32'd0);
      chk("t5_c_rdata", k, c_rdata[k], 32'd0);
      chk("t5_d_rdata", k, d_rdata[k], 32'd0);
      c_req[k] = 0; ack_lat[k] = -3;
    end
    rst = 1'b1;
    dn = 0;
    repeat (5) begin
      tick();
      for (int k = 0; k < NI; k++) if (c_done[k] || d_done[k]) dn++;
    end
    chk("t5_late_ack", 0, 32'(dn), 32'd0);

    // Randomized traffic with occasional resets.
    for (int k = 0; k < NI; k++) begin
      ack_lat[k] = -1; rd_fix_en[k] = 0;
    end
    for (int cy = 0; cy < 3000; cy++) begin
      tick();
      rst = ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1;
      for (int k = 0; k < NI; k++) begin
        if (c_req[k] && c_done[k]) begin
          if ($urandom_range(0, 3) == 0) rand_fields(k, 0);
          else                           c_req[k] = 0;
        end else if (!c_req[k] && $urandom_range(0, 2) == 0) begin
          rand_fields(k, 0);
          c_req[k] = 1;
        end
        if (d_req[k] && d_done[k]) begin
          if ($urandom_range(0, 3) == 0) rand_fields(k, 1);
          else                           d_req[k] = 0;
        end else if (!d_req[k] && $urandom_range(0, 2) == 0) begin
          rand_fields(k, 1);
          d_req[k] = 1;
        end
      end
    end

    rst = 1'b1;
    for (int k = 0; k < NI; k++) begin
      c_req[k] = 0;
      d_req[k] = 0;
    end
    repeat (10) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
